layer3_mac_accum: RTL
=====================

// Module: layer3_mac_accum
// PURPOSE
//  Consumer end of the Layer3 multiply array: takes N_LANES signed 32-bit products per beat
//  from the 16x16 DSP multipliers, reduces them through a pipelined adder tree, and
//  accumulates beats into one dot product.
//  On the beat flagged last: adds bias, rounds, shifts, saturates to 16 bits, applies optional
//  ReLU, and emits one output-feature value to the Layer3 output buffer over valid/ready.
// PARAMETERS
//  N_LANES   4   products per beat (power of 2, 2..16)
//  PROD_W    32  product width (signed)
//  ACC_W     40  accumulator width (signed); must be >= PROD_W+log2(N_LANES)
//  OUT_SHIFT 8   arithmetic right shift applied at finalize (0..ACC_W-17)
//  RELU_EN   1   1: negative results clamp to 0
// PORTS
//  ap_clk     in   1               clock, all logic on rising edge
//  ap_rst     in   1               synchronous, active-high reset
//  in_valid   in   1               product beat valid
//  in_ready   out  1               beat accepted when in_valid && in_ready
//  in_prod    in   N_LANES*PROD_W  lane i = bits [i*PROD_W +: PROD_W], signed
//  in_last    in   1               beat is the final beat of the current dot product
//  in_bias    in   32              signed bias; sampled only on an accepted last beat
//  out_valid  out  1               result valid; held until out_ready
//  out_ready  in   1               downstream accept
//  out_data   out  16              signed saturated result
//  out_sat    out  1               result was clipped by saturation (not by ReLU)
// BEHAVIOUR
//  Reset: in_ready=0 during reset, 1 the cycle after. out_valid=0, out_data=0, out_sat=0.
//   Accumulator=0, all pipeline valids=0, accumulator state=EMPTY.
//  Stall: en = !(out_valid && !out_ready). in_ready=en. Every pipeline register advances only when en=1.
//  Pipeline (beat accepted at cycle t, no stall):
//   t+1 tree level registers (pairwise sums, sign-extended +1 bit per level).
//   t+1+log2(N_LANES)-1 tree sum registered.
//   Next cycle: accumulate.
//   For N_LANES=4: tree sum at t+2, accumulate at t+3, out_valid at t+4 for the last beat.
//  Accumulator FSM (advances on a valid tree sum with en=1):
//   EMPTY: acc <= sext(sum); if last -> FINAL else -> ACCUM.
//   ACCUM: acc <= acc + sext(sum); if last -> FINAL.
//   FINAL: one-cycle finalize step. A new first beat may arrive in the same cycle.
//    It loads acc (EMPTY semantics) while the finished value goes to the finalize register.
//    Back-to-back dot products therefore have zero bubbles.
//  Bias travels with the last beat through the pipeline (delay-matched).
//  Accumulator wraps mod 2^ACC_W with no saturation; sizing is the caller's duty.
//  Finalize (combinational, then registered into out_data):
//   v = acc + sext(bias);
//   if OUT_SHIFT>0: v += 1<<(OUT_SHIFT-1) (round half up); v >>>= OUT_SHIFT.
//   Saturate to [-32768, 32767]; out_sat=1 if clipped.
//   If RELU_EN and the result is <0: out_data=0, out_sat=0.
//  Output register: loads when a finalize occurs and en=1. out_valid stays asserted and out_data is
//   stable while out_ready=0. Simultaneous out_ready and a new finalize: the register reloads, no drop.
//  A single-beat dot product (in_last on its first beat) is legal.
//  ap_rst mid-operation: the partial sum and all in-flight beats are discarded; no output is produced.
// STRUCTURE
//  layer3_pkg: LAYER3_PROD_W, LAYER3_ACC_W, LAYER3_OUT_W=16, SAT_MAX/SAT_MIN constants,
//   accumulator-state enum {EMPTY, ACCUM, FINAL}.
//  Sub-module layer3_mac_add_tree: parameterised registered binary adder tree
//   (N_LANES, PROD_W, en input, valid/last/bias sideband passed through).
//  The accumulator, finalize, and output register stay in this module.
// TESTING
//  1 Products {100,200,300,400}, last, bias=0, shift 0 -> out_data=1000 at t+4, out_sat=0.
//  2 Beat 1 {-1,-1,-1,-1}, beat 2 {2,2,2,2} last, RELU_EN=0, shift 0 -> out_data=4.
//    Repeat with RELU_EN=1 and beat 2 {0,0,0,0} last -> 0.
//  3 Single beat {0x4000_0000 x4}, shift 8 -> saturates: out_data=32767, out_sat=1.
//    Repeat with negated products -> -32768, out_sat=1 (RELU_EN=0).
//  4 Rounding, shift 8: sum=384 (1.5 units) -> 2; sum=-384 -> -1; bias=128 with sum=0 -> 1.
//  5 Back-to-back single-beat dot products every cycle, out_ready toggling 1010...:
//    every result is delivered once, in order; in_ready=0 exactly while out_valid && !out_ready.
//  6 Assert ap_rst after 2 of 3 beats, then send a fresh 1-beat product {1,1,1,1} last:
//    only out_data=4 appears; no stale partial sum.

Source files
------------

// File: rtl/layer3_pkg.sv
// Shared widths, saturation limits and accumulator states for the Layer3 MAC consumer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package layer3_pkg;

  localparam int LAYER3_PROD_W = 32;
  localparam int LAYER3_ACC_W  = 40;
  localparam int LAYER3_OUT_W  = 16;
  localparam int LAYER3_BIAS_W = 32;
  localparam int SAT_MAX       = 32767;
  localparam int SAT_MIN       = -32768;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ACCUM,
    ST_FINAL
  } acc_state_e;

endpackage

// File: rtl/layer3_mac_accum_if.sv
// Product-beat input and result output handshakes of the Layer3 MAC accumulator.
// Latency: n/a (wires only).
// Backpressure: in_ready / out_ready follow valid/ready semantics.
interface layer3_mac_accum_if
  import layer3_pkg::*;
#(
  parameter int N_LANES = 4,
  parameter int PROD_W  = LAYER3_PROD_W
);

  logic                             in_valid;
  logic                             in_ready;
  logic [N_LANES*PROD_W-1:0]        in_prod;
  logic                             in_last;
  logic signed [LAYER3_BIAS_W-1:0]  in_bias;
  logic                             out_valid;
  logic                             out_ready;
  logic signed [LAYER3_OUT_W-1:0]   out_data;
  logic                             out_sat;

  // Producer/consumer side (multiplier array and output buffer).
  modport master (
    output in_valid, in_prod, in_last, in_bias, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  // The accumulator itself.
  modport slave (
    input  in_valid, in_prod, in_last, in_bias, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );

endinterface

// File: rtl/layer3_mac_add_tree.sv
// Registered binary adder tree: sums N_LANES signed products, one register level per tree level.
// Latency: log2(N_LANES) cycles; valid/last/bias sideband delayed to match.
// Backpressure: every register holds while en_i is low.
module layer3_mac_add_tree
  import layer3_pkg::*;
#(
  parameter int N_LANES = 4,
  parameter int PROD_W  = LAYER3_PROD_W,
  localparam int LEVELS = $clog2(N_LANES),
  localparam int SUM_W  = PROD_W + LEVELS
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en_i,
  input  logic                            vld_i,
  input  logic                            last_i,
  input  logic signed [LAYER3_BIAS_W-1:0] bias_i,
  input  logic [N_LANES*PROD_W-1:0]       prod_i,
  output logic                            vld_o,
  output logic                            last_o,
  output logic signed [LAYER3_BIAS_W-1:0] bias_o,
  output logic signed [SUM_W-1:0]         sum_o
);

  localparam int HALF = N_LANES / 2;

  // Every level uses the final width; sign extension keeps the partial sums exact.
  logic signed [SUM_W-1:0]         node_q [LEVELS][HALF];
  logic [LEVELS-1:0]               vld_q;
  logic [LEVELS-1:0]               last_q;
  logic signed [LAYER3_BIAS_W-1:0] bias_q [LEVELS];

  // Valid pipeline: the only tree state that needs clearing, so in-flight beats vanish on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else if (en_i) begin
      vld_q[0] <= vld_i;
      for (int k = 1; k < LEVELS; k++) vld_q[k] <= vld_q[k-1];
    end
  end

  // Pairwise sums per level plus the delay-matched last/bias sideband.
  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int i = 0; i < HALF; i++) begin
        node_q[0][i] <= SUM_W'($signed(prod_i[2*i*PROD_W +: PROD_W]))
                      + SUM_W'($signed(prod_i[(2*i+1)*PROD_W +: PROD_W]));
      end
      for (int k = 1; k < LEVELS; k++) begin
        for (int i = 0; i < (N_LANES >> (k+1)); i++) begin
          node_q[k][i] <= node_q[k-1][2*i] + node_q[k-1][2*i+1];
        end
      end
      last_q[0] <= last_i;
      bias_q[0] <= bias_i;
      for (int k = 1; k < LEVELS; k++) begin
        last_q[k] <= last_q[k-1];
        bias_q[k] <= bias_q[k-1];
      end
    end
  end

  assign vld_o  = vld_q[LEVELS-1];
  assign last_o = last_q[LEVELS-1];
  assign bias_o = bias_q[LEVELS-1];
  assign sum_o  = node_q[LEVELS-1][0];

endmodule

// File: rtl/layer3_mac_accum.sv
// Layer3 MAC consumer: adder tree, beat accumulator, bias/round/shift/saturate/ReLU finalize.
// Latency: log2(N_LANES)+2 cycles from accepted last beat to out_valid (4 for N_LANES=4).
// Backpressure: whole pipeline freezes while out_valid && !out_ready; in_ready mirrors that.
module layer3_mac_accum
  import layer3_pkg::*;
#(
  parameter int N_LANES   = 4,
  parameter int PROD_W    = LAYER3_PROD_W,
  parameter int ACC_W     = LAYER3_ACC_W,
  parameter int OUT_SHIFT = 8,
  parameter int RELU_EN   = 1
) (
  input  logic ap_clk,
  input  logic ap_rst,
  layer3_mac_accum_if.slave io
);

  localparam int LEVELS = $clog2(N_LANES);
  localparam int SUM_W  = PROD_W + LEVELS;
  // Two guard bits so bias and rounding never wrap before the shift.
  localparam int FIN_W  = ACC_W + 2;
  localparam logic signed [FIN_W-1:0] ROUND_K =
    (OUT_SHIFT > 0) ? (FIN_W'(1) << ((OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0)) : '0;

  logic                            en;
  logic                            ready_ok_q;
  logic                            t_vld;
  logic                            t_last;
  logic signed [LAYER3_BIAS_W-1:0] t_bias;
  logic signed [SUM_W-1:0]         t_sum;

  acc_state_e                      state_q, state_d;
  logic signed [ACC_W-1:0]         acc_q, acc_d;
  logic signed [LAYER3_BIAS_W-1:0] bias_q, bias_d;
  logic                            fin;

  logic signed [FIN_W-1:0]         fin_sum;
  logic signed [FIN_W-1:0]         fin_shr;
  logic signed [LAYER3_OUT_W-1:0]  fin_dat;
  logic                            fin_sat;

  logic                            out_valid_q;
  logic signed [LAYER3_OUT_W-1:0]  out_data_q;
  logic                            out_sat_q;

  assign en          = !(out_valid_q && !io.out_ready);
  assign io.in_ready = en && ready_ok_q;

  layer3_mac_add_tree #(
    .N_LANES (N_LANES),
    .PROD_W  (PROD_W)
  ) u_tree (
    .clk    (ap_clk),
    .rst    (ap_rst),
    .en_i   (en),
    .vld_i  (io.in_valid && io.in_ready),
    .last_i (io.in_last),
    .bias_i (io.in_bias),
    .prod_i (io.in_prod),
    .vld_o  (t_vld),
    .last_o (t_last),
    .bias_o (t_bias),
    .sum_o  (t_sum)
  );

  // Hold in_ready low through reset and release it one cycle later.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) ready_ok_q <= 1'b0;
    else        ready_ok_q <= 1'b1;
  end

  // Accumulator FSM: FINAL doubles as EMPTY so a new dot product can start with no bubble.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    bias_d  = bias_q;
    fin     = (state_q == ST_FINAL);
    if (en) begin
      if (t_vld) begin
        if (state_q == ST_ACCUM) acc_d = acc_q + ACC_W'(t_sum);
        else                     acc_d = ACC_W'(t_sum);
        state_d = t_last ? ST_FINAL : ST_ACCUM;
        if (t_last) bias_d = t_bias;
      end else if (state_q == ST_FINAL) begin
        state_d = ST_EMPTY;
      end
    end
  end

  // Accumulator state registers.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= ST_EMPTY;
      acc_q   <= '0;
      bias_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      bias_q  <= bias_d;
    end
  end

  // Finalize: bias, round half up, arithmetic shift, saturate, then ReLU overrides.
  always_comb begin
    fin_sum = FIN_W'(acc_q) + FIN_W'(bias_q) + ROUND_K;
    fin_shr = fin_sum >>> OUT_SHIFT;
    fin_dat = fin_shr[LAYER3_OUT_W-1:0];
    fin_sat = 1'b0;
    if (fin_shr > FIN_W'(SAT_MAX)) begin
      fin_dat = LAYER3_OUT_W'(SAT_MAX);
      fin_sat = 1'b1;
    end else if (fin_shr < FIN_W'(SAT_MIN)) begin
      fin_dat = LAYER3_OUT_W'(SAT_MIN);
      fin_sat = 1'b1;
    end
    if (RELU_EN != 0 && fin_shr < 0) begin
      fin_dat = '0;
      fin_sat = 1'b0;
    end
  end

  // Output register: en low means a result is held, so it only ever changes when en is high.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else if (en) begin
      out_valid_q <= fin;
      if (fin) begin
        out_data_q <= fin_dat;
        out_sat_q  <= fin_sat;
      end
    end
  end

  assign io.out_valid = out_valid_q;
  assign io.out_data  = out_data_q;
  assign io.out_sat   = out_sat_q;

endmodule
